// File: rtl/vga_scan_timer_if.sv
// Raster timing bundle produced by vga_scan_timer and consumed by the object
// stages (paddle, ball, carpet).
interface vga_scan_timer_if;
  logic [15:0] col;
  logic [15:0] row;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        pix_en;
  logic        frame;

  modport master (
    output col, row, hsync, vsync, video_on, pix_en, frame
  );

  modport slave (
    input col, row, hsync, vsync, video_on, pix_en, frame
  );
endinterface

// File: rtl/vga_scan_timer.sv
// VGA raster generator: pixel-enable divider, column/row scan counters,
// registered active-low syncs, visible-area flag and end-of-frame strobe.
module vga_scan_timer #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic              clk,
  input  logic              reset,
  vga_scan_timer_if.master  vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0]  DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_LAST   = 16'(V_TOTAL - 1);
  localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
  localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
  localparam logic [15:0] HS_START = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_END   = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_START = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_END   = 16'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [3:0]  div_cnt_q, div_cnt_d;
  logic [15:0] col_q, col_d;
  logic [15:0] row_q, row_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic        pix_en_q, pix_en_d;
  logic        frame_q, frame_d;
  logic        px_tick;

  // The counters advance on the last divider phase; pix_en is the registered
  // copy of that phase so it stays low while reset is held, even for CLK_DIV=1.
  always_comb begin
    px_tick   = (div_cnt_q == DIV_LAST);
    div_cnt_d = px_tick ? 4'd0 : div_cnt_q + 4'd1;
    col_d     = col_q;
    row_d     = row_q;
    if (px_tick) begin
      if (col_q == H_LAST) begin
        col_d = 16'd0;
        row_d = (row_q == V_LAST) ? 16'd0 : row_q + 16'd1;
      end else begin
        col_d = col_q + 16'd1;
      end
    end
  end

  // Outputs decoded from the next counter state so they update on the same
  // edge as col/row; frame only fires on the edge that enters (0, V_ACTIVE).
  always_comb begin
    pix_en_d   = (div_cnt_d == DIV_LAST);
    hsync_d    = !((col_d >= HS_START) && (col_d <= HS_END));
    vsync_d    = !((row_d >= VS_START) && (row_d <= VS_END));
    video_on_d = (col_d < H_VIS) && (row_d < V_VIS);
    frame_d    = px_tick && (col_d == 16'd0) && (row_d == V_VIS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q  <= 4'd0;
      col_q      <= 16'd0;
      row_q      <= 16'd0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      video_on_q <= 1'b1;
      pix_en_q   <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      div_cnt_q  <= div_cnt_d;
      col_q      <= col_d;
      row_q      <= row_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      video_on_q <= video_on_d;
      pix_en_q   <= pix_en_d;
      frame_q    <= frame_d;
    end
  end

  assign vga.col      = col_q;
  assign vga.row      = row_q;
  assign vga.hsync    = hsync_q;
  assign vga.vsync    = vsync_q;
  assign vga.video_on = video_on_q;
  assign vga.pix_en   = pix_en_q;
  assign vga.frame    = frame_q;

endmodule

// File: tb/tb_vga_scan_timer.sv
// Bench for vga_scan_timer: default, small-raster and CLK_DIV=1 instances
// compared every clk against a closed-form raster model.
module tb_vga_scan_timer;

  typedef struct packed {
    logic [15:0] col;
    logic [15:0] row;
    logic        hs;
    logic        vs;
    logic        von;
    logic        pen;
    logic        frm;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   k = 0;          // clk edges since the last reset edge
  logic valid = 1'b0;   // set once the DUTs have seen reset
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  vga_scan_timer_if if_def ();
  vga_scan_timer_if if_sm2 ();
  vga_scan_timer_if if_sm1 ();

  vga_scan_timer u_def (.clk(clk), .reset(reset), .vga(if_def.master));

  vga_scan_timer #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_sm2 (.clk(clk), .reset(reset), .vga(if_sm2.master));

  vga_scan_timer #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_sm1 (.clk(clk), .reset(reset), .vga(if_sm1.master));

  // Raster position is just the pixel index k/div folded into the frame.
  function automatic exp_t model(input int kk, input int div,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb);
    exp_t m;
    int ht, vt, p, c, r;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = kk / div;
    c  = p % ht;
    r  = (p / ht) % vt;
    m.col = 16'(c);
    m.row = 16'(r);
    m.hs  = !(c >= ha + hf && c < ha + hf + hs);
    m.vs  = !(r >= va + vf && r < va + vf + vs);
    m.von = (c < ha) && (r < va);
    m.pen = (kk >= 1) && (kk % div == div - 1);
    m.frm = (kk >= 1) && (kk % div == 0) && (c == 0) && (r == va);
    return m;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at k=%0d: got %0d expected %0d", name, k, act, exp);
    end
  endtask

  task automatic chk_inst(input string tag, input exp_t e,
                          input logic [15:0] col, input logic [15:0] row,
                          input logic hs, input logic vs, input logic von,
                          input logic pen, input logic frm);
    chk({tag, ".col"}, col, e.col);
    chk({tag, ".row"}, row, e.row);
    chk({tag, ".hsync"}, 16'(hs), 16'(e.hs));
    chk({tag, ".vsync"}, 16'(vs), 16'(e.vs));
    chk({tag, ".video_on"}, 16'(von), 16'(e.von));
    chk({tag, ".pix_en"}, 16'(pen), 16'(e.pen));
    chk({tag, ".frame"}, 16'(frm), 16'(e.frm));
  endtask

  always @(posedge clk) begin
    if (reset) begin
      k     <= 0;
      valid <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  // Compare every cycle against the model, plus literal pins of the model.
  always @(negedge clk) begin
    if (valid) begin
      chk_inst("def", model(k, 4, 640, 16, 96, 48, 480, 10, 2, 33),
               if_def.col, if_def.row, if_def.hsync, if_def.vsync,
               if_def.video_on, if_def.pix_en, if_def.frame);
      chk_inst("sm2", model(k, 2, 8, 1, 2, 1, 4, 1, 1, 1),
               if_sm2.col, if_sm2.row, if_sm2.hsync, if_sm2.vsync,
               if_sm2.video_on, if_sm2.pix_en, if_sm2.frame);
      chk_inst("sm1", model(k, 1, 8, 1, 2, 1, 4, 1, 1, 1),
               if_sm1.col, if_sm1.row, if_sm1.hsync, if_sm1.vsync,
               if_sm1.video_on, if_sm1.pix_en, if_sm1.frame);

      if (k == 0) begin
        chk("pin_rst_col", if_def.col, 16'd0);
        chk("pin_rst_hsync", 16'(if_def.hsync), 16'd1);
        chk("pin_rst_video_on", 16'(if_def.video_on), 16'd1);
        chk("pin_rst_pix_en1", 16'(if_sm1.pix_en), 16'd0);
      end
      if (k == 1) chk("pin_div1_pix_en", 16'(if_sm1.pix_en), 16'd1);
      if (k == 2) chk("pin_pix_en_lo", 16'(if_def.pix_en), 16'd0);
      if (k == 3) chk("pin_pix_en_hi", 16'(if_def.pix_en), 16'd1);
      if (k == 7) chk("pin_pix_en_rep", 16'(if_def.pix_en), 16'd1);
      if (k == 2560) chk("pin_video_off", 16'(if_def.video_on), 16'd0);
      if (k == 2623) chk("pin_hsync_pre", 16'(if_def.hsync), 16'd1);
      if (k == 2624) begin
        chk("pin_hsync_col", if_def.col, 16'd656);
        chk("pin_hsync_fall", 16'(if_def.hsync), 16'd0);
      end
      if (k == 3008) chk("pin_hsync_rise", 16'(if_def.hsync), 16'd1);
      if (k == 3200) begin
        chk("pin_line_col", if_def.col, 16'd0);
        chk("pin_line_row", if_def.row, 16'd1);
      end
      if (k == 96) chk("pin_sm2_frame", 16'(if_sm2.frame), 16'd1);
      if (k == 97) chk("pin_sm2_frame_once", 16'(if_sm2.frame), 16'd0);
      if (k == 168) chk("pin_sm2_wrap_row", if_sm2.row, 16'd0);
      if (k == 48) chk("pin_sm1_frame", 16'(if_sm1.frame), 16'd1);
      if (k == 132) chk("pin_sm1_frame2", 16'(if_sm1.frame), 16'd1);
    end
  end

  initial begin
    bit found;
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Clean run past the first default line and several small frames.
    repeat (3300) @(negedge clk);

    // Random reset pulses at arbitrary divider phases and raster positions.
    for (int i = 0; i < 15000; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      @(negedge clk);
    end
    reset = 1'b0;
    repeat (400) @(negedge clk);

    // Reset while the small raster has both syncs low.
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (if_sm2.row == 16'd5 && if_sm2.col == 16'd10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midframe_wait: sync window not reached within 1000 clks");
    end else begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    repeat (600) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
